// File: rtl/alu_seq_if.sv
// alu_seq request/response bundle.
// master drives start/A/B/selector; slave returns result, flags, busy, done.
interface alu_seq_if #(
  parameter int BUS_SIZE = 32
);
  logic                start;
  logic [BUS_SIZE-1:0] A;
  logic [BUS_SIZE-1:0] B;
  logic [3:0]          selector;
  logic [BUS_SIZE-1:0] R;
  logic [BUS_SIZE-1:0] R_hi;
  logic                flagZ;
  logic                flagN;
  logic                flagC;
  logic                flagV;
  logic                divZero;
  logic                busy;
  logic                done;

  modport master (
    output start, A, B, selector,
    input  R, R_hi, flagZ, flagN, flagC, flagV,
    input  divZero, busy, done
  );

  modport slave (
    input  start, A, B, selector,
    output R, R_hi, flagZ, flagN, flagC, flagV,
    output divZero, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/shift ops plus
// iterative MULU/DIVU. Ports: clk, reset (async high), bus (alu_seq_if.slave).
module alu_seq #(
  parameter int BUS_SIZE = 32,
  parameter int SHAMT_W  = 5
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);
  localparam logic [3:0] OP_SUM  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_MULU = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;

  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(BUS_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, nextState;

  logic [BUS_SIZE-1:0] aReg, bReg;
  logic [3:0]          opReg;
  logic [SHAMT_W-1:0]  cnt;
  logic [BUS_SIZE-1:0] accHi, accLo;

  logic [BUS_SIZE-1:0] rReg, rHiReg;
  logic zReg, nReg, cReg, vReg;
  logic dzReg, busyReg, doneReg;

  logic startCalc;
  logic [BUS_SIZE-1:0] stepHi, stepLo;
  logic [BUS_SIZE-1:0] resLo, resHi;
  logic cOut, vOut, dzOut;

  // Iterative ops that need the CALC loop; DIVU by zero finishes at once.
  assign startCalc = (bus.selector == OP_MULU) ||
                     ((bus.selector == OP_DIVU) && (bus.B != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          nextState = startCalc ? CALC : DONE;
        end
      end
      CALC: begin
        if (cnt == LAST) begin
          nextState = DONE;
        end
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  // MULU: accHi = partial high word, accLo = multiplier shifting out.
  // DIVU: accHi = partial remainder, accLo = dividend in / quotient out.
  logic [BUS_SIZE:0] mulSum;
  logic [BUS_SIZE:0] divShift;
  logic [BUS_SIZE:0] divTrial;

  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, aReg} : '0);
    divShift = {accHi, accLo[BUS_SIZE-1]};
    divTrial = divShift - {1'b0, bReg};
    stepHi   = accHi;
    stepLo   = accLo;
    if (opReg == OP_MULU) begin
      stepHi = mulSum[BUS_SIZE:1];
      stepLo = {mulSum[0], accLo[BUS_SIZE-1:1]};
    end else if (!divTrial[BUS_SIZE]) begin
      stepHi = divTrial[BUS_SIZE-1:0];
      stepLo = {accLo[BUS_SIZE-2:0], 1'b1};
    end else begin
      stepHi = divShift[BUS_SIZE-1:0];
      stepLo = {accLo[BUS_SIZE-2:0], 1'b0};
    end
  end

  logic [BUS_SIZE:0]   addW, subW;
  logic [SHAMT_W-1:0]  shamt;

  always_comb begin
    addW  = {1'b0, aReg} + {1'b0, bReg};
    subW  = {1'b0, aReg} + {1'b0, ~bReg} +
            {{BUS_SIZE{1'b0}}, 1'b1};
    shamt = bReg[SHAMT_W-1:0];
    resLo = '0;
    resHi = '0;
    cOut  = 1'b0;
    vOut  = 1'b0;
    dzOut = 1'b0;
    unique case (opReg)
      OP_SUM: begin
        resLo = addW[BUS_SIZE-1:0];
        cOut  = addW[BUS_SIZE];
        vOut  = (aReg[BUS_SIZE-1] == bReg[BUS_SIZE-1]) &&
                (addW[BUS_SIZE-1] != aReg[BUS_SIZE-1]);
      end
      OP_SUB: begin
        resLo = subW[BUS_SIZE-1:0];
        cOut  = subW[BUS_SIZE];
        vOut  = (aReg[BUS_SIZE-1] != bReg[BUS_SIZE-1]) &&
                (subW[BUS_SIZE-1] != aReg[BUS_SIZE-1]);
      end
      OP_AND: resLo = aReg & bReg;
      OP_OR:  resLo = aReg | bReg;
      OP_XOR: resLo = aReg ^ bReg;
      OP_SLT: begin
        resLo = {{(BUS_SIZE-1){1'b0}},
                 ($signed(aReg) < $signed(bReg))};
      end
      OP_SLL: resLo = aReg << shamt;
      OP_SRL: resLo = aReg >> shamt;
      OP_SRA: resLo = BUS_SIZE'($signed(aReg) >>> shamt);
      OP_MULU: begin
        resLo = accLo;
        resHi = accHi;
        cOut  = |accHi;
      end
      OP_DIVU: begin
        if (bReg == '0) begin
          resLo = '1;
          resHi = aReg;
          dzOut = 1'b1;
        end else begin
          resLo = accLo;
          resHi = accHi;
        end
      end
      default: begin
        resLo = '0;
        resHi = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aReg    <= '0;
      bReg    <= '0;
      opReg   <= '0;
      cnt     <= '0;
      accHi   <= '0;
      accLo   <= '0;
      rReg    <= '0;
      rHiReg  <= '0;
      zReg    <= 1'b0;
      nReg    <= 1'b0;
      cReg    <= 1'b0;
      vReg    <= 1'b0;
      dzReg   <= 1'b0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            aReg    <= bus.A;
            bReg    <= bus.B;
            opReg   <= bus.selector;
            cnt     <= '0;
            accHi   <= '0;
            accLo   <= (bus.selector == OP_MULU) ? bus.B : bus.A;
            busyReg <= startCalc;
          end
        end
        CALC: begin
          cnt   <= cnt + SHAMT_W'(1);
          accHi <= stepHi;
          accLo <= stepLo;
        end
        DONE: begin
          rReg    <= resLo;
          rHiReg  <= resHi;
          zReg    <= (resLo == '0);
          nReg    <= resLo[BUS_SIZE-1];
          cReg    <= cOut;
          vReg    <= vOut;
          dzReg   <= dzOut;
          busyReg <= 1'b0;
          doneReg <= 1'b1;
        end
        default: begin
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.R       = rReg;
  assign bus.R_hi    = rHiReg;
  assign bus.flagZ   = zReg;
  assign bus.flagN   = nReg;
  assign bus.flagC   = cReg;
  assign bus.flagV   = vReg;
  assign bus.divZero = dzReg;
  assign bus.busy    = busyReg;
  assign bus.done    = doneReg;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle, parametrised successor of the datapath ALU.
- Adds shifts, signed compare, iterative unsigned multiply and divide, registered flags including overflow, and a start/busy/done handshake.
- Sits in the execute stage; the control unit issues `start` and stalls the pipeline while `busy` is high.
- All outputs are registered and hold their value until the next completion.

Parameters:
- BUS_SIZE, 32: operand and result width.
- SHAMT_W, 5: shift-amount width taken from B; must equal log2(BUS_SIZE).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  BUS_SIZE  operand A, latched on accepted start
- B  input  BUS_SIZE  operand B, latched on accepted start
- selector  input  4  operation code, latched on accepted start
- R  output  BUS_SIZE  result; low word for MULU, quotient for DIVU
- R_hi  output  BUS_SIZE  MULU high word; DIVU remainder; 0 for all other ops
- flagZ  output  1  R == 0
- flagN  output  1  R[BUS_SIZE-1]
- flagC  output  1  carry / no-borrow / MULU high-word-nonzero
- flagV  output  1  signed overflow (SUM/SUB only)
- divZero  output  1  last DIVU had B == 0
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-high):
  - R, R_hi, all flags, divZero, busy and done go to 0.
  - FSM goes to IDLE.
  - Reset during CALC aborts the operation with no done pulse.
- Selector encoding:
  - 0000 SUM, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLT (signed A<B gives R=1, else 0)
  - 0110 SLL, 0111 SRL, 1000 SRA; shift amount is B[SHAMT_W-1:0]
  - 1001 MULU, 1010 DIVU
  - 1011-1111: R=0, R_hi=0; treated as a single-cycle op
- FSM states and transitions:
  - IDLE: on start=1, latch A, B and selector. If op is MULU, or DIVU with B≠0, go to CALC and set busy=1 from the next edge. Otherwise go to DONE.
  - CALC: iteration counter counts from 0 to BUS_SIZE-1, one iteration per cycle.
    - MULU is shift-add.
    - DIVU is restoring, one quotient bit per cycle.
    - After iteration BUS_SIZE-1, go to DONE.
  - DONE: for one cycle, write R, R_hi, flags and divZero, assert done=1 and clear busy. Then return to IDLE.
- Latency, measured from the edge sampling start to the edge where done is seen high:
  - Single-cycle ops: 2 cycles (accept edge, then DONE edge).
  - MULU and DIVU: BUS_SIZE+2 cycles.
  - Back-to-back: start may be re-asserted in the cycle after done (IDLE).
- Handshake: start while busy=1 or in DONE is ignored, not queued. A, B and selector may change freely after acceptance.
- Arithmetic and flag rules:
  - SUM: {C,R} = A+B with a (BUS_SIZE+1)-bit sum. V = (A and B same sign) and (R sign differs).
  - SUB: R = A + ~B + 1. C = carry out (1 when A ≥ B unsigned). V = (A and B signs differ) and (R sign ≠ A sign).
  - MULU: {R_hi,R} = A*B as a full 2*BUS_SIZE product. C = (R_hi ≠ 0).
  - DIVU, B≠0: R = A/B, R_hi = A%B.
  - DIVU, B=0: single-cycle; R = all ones, R_hi = A, divZero=1.
  - Every completion other than DIVU by zero clears divZero.
  - C and V are 0 for all ops not listed above. Z and N always derive from the new R.
  - Shift amount 0 passes A unchanged. SRA fills with A[BUS_SIZE-1].

Test Plan:
- Reset mid-MULU: start MULU A=7, B=9; assert reset 10 cycles later → busy=0, R=0, no done pulse; a following SUM A=1, B=2 → R=3.
- SUM carry: SUM A=32'hFFFFFFFF, B=1 → R=0, flagZ=1, flagC=1, flagV=0, done exactly 2 cycles after start. SUM A=32'h7FFFFFFF, B=1 → R=32'h80000000, flagV=1, flagN=1.
- SUB and SLT: SUB A=3, B=5 → R=32'hFFFFFFFE, flagN=1, flagC=0. SLT A=32'hFFFFFFFF, B=1 → R=1.
- MULU: A=32'h10000, B=32'h10000 → R=0, R_hi=1, flagC=1, flagZ=1, done 34 cycles after start. A start pulsed while busy has no effect.
- DIVU: A=100, B=7 → R=14, R_hi=2, latency 34 cycles. A=5, B=0 → R=32'hFFFFFFFF, R_hi=5, divZero=1, latency 2 cycles.
- Shifts: SRA A=32'h80000000, B=31 → R=32'hFFFFFFFF. SRL same operands → R=1. SLL A=1, B=32'h25 (shamt 5) → R=32. Selector 1111 → R=0, flagZ=1.
